// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Package : sw_pkg
// Shared types and sizes for the Smith-Waterman stripe feeder.
// Rev     : 1.0
// ============================================================================
package sw_pkg;

  localparam int SEQ_LEN  = 1024;
  localparam int PE_NUM   = 64;
  localparam int N_STRIPE = SEQ_LEN / PE_NUM;
  localparam int SCORE_W  = 14;
  localparam int TMO_CYC  = 2000;
  localparam int ADDR_W   = 10;
  localparam int POS_W    = 11;
  localparam int K_W      = 4;

  typedef logic [1:0] base_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADB  = 3'd1,
    ST_GAP    = 3'd2,
    ST_STREAM = 3'd3,
    ST_UPD    = 3'd4,
    ST_TRACE  = 3'd5,
    ST_DONE   = 3'd6
  } feeder_st_e;

endpackage
`default_nettype wire

// File: rtl/sw_stripe_feeder_if.sv
`default_nettype none
// ============================================================================
// Interface : sw_stripe_feeder_if
// Feeder <-> PE_array_64 stripe link (stream out, stripe report back).
// Rev       : 1.0
// ============================================================================
interface sw_stripe_feeder_if;
  import sw_pkg::*;

  logic                  o_pe_start;
  base_t                 o_pe_A;
  logic [2*PE_NUM-1:0]   o_pe_B;
  logic                  i_pe_stripe_end;
  logic [ADDR_W-1:0]     i_pe_start_position;
  logic [ADDR_W-1:0]     i_pe_end_position;
  logic [SCORE_W-1:0]    i_pe_max_score;

  modport master (
    output o_pe_start, o_pe_A, o_pe_B,
    input  i_pe_stripe_end, i_pe_start_position, i_pe_end_position, i_pe_max_score
  );

  modport slave (
    input  o_pe_start, o_pe_A, o_pe_B,
    output i_pe_stripe_end, i_pe_start_position, i_pe_end_position, i_pe_max_score
  );

endinterface
`default_nettype wire

// File: rtl/sw_best_tracker.sv
`default_nettype none
// ============================================================================
// Module : sw_best_tracker
// Running strict-greater maximum score with its absolute end position.
// Rev    : 1.0
// ============================================================================
module sw_best_tracker
  import sw_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_update,
  input  logic [SCORE_W-1:0]  i_score,
  input  logic [POS_W-1:0]    i_end,
  output logic [SCORE_W-1:0]  o_best_score,
  output logic [POS_W-1:0]    o_best_end
);

  logic [SCORE_W-1:0] r_score;
  logic [POS_W-1:0]   r_end;

  // Strict compare: on a tie the earlier stripe keeps ownership.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_score <= '0;
      r_end   <= '0;
    end else if (i_clear) begin
      r_score <= '0;
      r_end   <= '0;
    end else if (i_update && (i_score > r_score)) begin
      r_score <= i_score;
      r_end   <= i_end;
    end
  end

  assign o_best_score = r_score;
  assign o_best_end   = r_end;

endmodule
`default_nettype wire

// File: rtl/sw_stripe_feeder.sv
`default_nettype none
// ============================================================================
// Module : sw_stripe_feeder
// Stripe sequencer for PE_array_64: loads B rows, streams A with chained
// start positions, tracks the global best. Option macro: FEEDER_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module sw_stripe_feeder
  import sw_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_go,
  output logic [ADDR_W-1:0]    o_a_addr,
  input  base_t                i_a_data,
  output logic [K_W-1:0]       o_b_addr,
  input  logic [2*PE_NUM-1:0]  i_b_data,
  sw_stripe_feeder_if.master   pe,
  output logic [K_W-1:0]       o_stripe_idx,
  output logic [SCORE_W-1:0]   o_best_score,
  output logic [POS_W-1:0]     o_best_end,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam logic [K_W-1:0] c_k_last  = K_W'(N_STRIPE - 1);
  localparam logic [POS_W:0] c_seq_len = SEQ_LEN[POS_W:0];

  feeder_st_e            r_state;
  feeder_st_e            w_next;
  logic [K_W-1:0]        r_k;
  logic [POS_W-1:0]      r_spos;
  logic [POS_W-1:0]      r_j;
  logic                  r_pe_start;
  logic [2*PE_NUM-1:0]   r_pe_B;
  logic [ADDR_W-1:0]     r_st_pos;
  logic [ADDR_W-1:0]     r_end_pos;
  logic [SCORE_W-1:0]    r_score;
  logic                  r_fall;
  logic                  w_go;
  logic                  w_issue;
  logic                  w_upd;
  logic [POS_W:0]        w_spos_sum;
  logic [POS_W-1:0]      w_spos_next;
  logic [POS_W-1:0]      w_abs_end;

  assign w_go    = i_go && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_issue = (r_state == ST_STREAM) && (r_j < c_seq_len[POS_W-1:0]);
  assign w_upd   = (r_state == ST_UPD);

  assign w_spos_sum  = {1'b0, r_spos} + {2'b00, r_st_pos};
  assign w_spos_next = (w_spos_sum >= c_seq_len) ? c_seq_len[POS_W-1:0] : w_spos_sum[POS_W-1:0];
  assign w_abs_end   = {1'b0, r_end_pos} + r_spos;

`ifdef FEEDER_TIMEOUT_EN
  logic [11:0] r_tmo;
  logic        r_err;
  logic        w_tmo_hit;

  assign w_tmo_hit = (r_state == ST_STREAM) && (r_tmo == 12'(TMO_CYC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_GAP)
        r_tmo <= '0;
      else if (r_state == ST_STREAM)
        r_tmo <= r_tmo + 1'b1;
      if (w_go)
        r_err <= 1'b0;
      else if (w_tmo_hit && !pe.i_pe_stripe_end)
        r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // The B ROM has one cycle of latency, so the row address leads LOADB by a cycle.
  always_comb begin
    w_next   = r_state;
    o_b_addr = r_k;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        o_b_addr = '0;
        if (i_go) w_next = ST_LOADB;
      end
      ST_LOADB: w_next = ST_GAP;
      ST_GAP:   w_next = ST_STREAM;
      ST_STREAM: begin
        if (pe.i_pe_stripe_end)
          w_next = ST_UPD;
`ifdef FEEDER_TIMEOUT_EN
        else if (w_tmo_hit)
          w_next = ST_DONE;
`endif
      end
      ST_UPD: begin
        o_b_addr = r_k + 1'b1;
        w_next   = (r_k == c_k_last) ? ST_TRACE : ST_LOADB;
      end
      ST_TRACE: if (r_fall && pe.i_pe_stripe_end) w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k        <= '0;
      r_spos     <= '0;
      r_j        <= '0;
      r_pe_start <= 1'b0;
      r_pe_B     <= '0;
      r_st_pos   <= '0;
      r_end_pos  <= '0;
      r_score    <= '0;
      r_fall     <= 1'b0;
    end else begin
      // A stripe end cancels the read issued in the same cycle.
      r_pe_start <= w_issue && !pe.i_pe_stripe_end;
      if (w_go) begin
        r_k    <= '0;
        r_spos <= '0;
      end
      if (r_state == ST_LOADB)
        r_pe_B <= i_b_data;
      if (r_state == ST_GAP)
        r_j <= r_spos;
      else if (w_issue)
        r_j <= r_j + 1'b1;
      if ((r_state == ST_STREAM) && pe.i_pe_stripe_end) begin
        r_st_pos  <= pe.i_pe_start_position;
        r_end_pos <= pe.i_pe_end_position;
        r_score   <= pe.i_pe_max_score;
      end
      if (w_upd) begin
        r_spos <= w_spos_next;
        if (r_k == c_k_last)
          r_pe_B <= '0;
        else
          r_k <= r_k + 1'b1;
      end
      if (w_upd)
        r_fall <= 1'b0;
      else if ((r_state == ST_TRACE) && !pe.i_pe_stripe_end)
        r_fall <= 1'b1;
    end
  end

  sw_best_tracker u_best (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_go),
    .i_update     (w_upd),
    .i_score      (r_score),
    .i_end        (w_abs_end),
    .o_best_score (o_best_score),
    .o_best_end   (o_best_end)
  );

  assign o_a_addr      = w_issue ? r_j[ADDR_W-1:0] : '0;
  assign pe.o_pe_start = r_pe_start;
  assign pe.o_pe_A     = r_pe_start ? i_a_data : '0;
  assign pe.o_pe_B     = r_pe_B;
  assign o_stripe_idx  = r_k;
  assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sw_stripe_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_sw_stripe_feeder
// Directed table-driven bench for sw_stripe_feeder with ROM and array models.
// Rev    : 1.0
// ============================================================================
module tb_sw_stripe_feeder;
  import sw_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go  = 1'b0;
  logic [9:0]    a_addr;
  base_t         a_data = '0;
  logic [3:0]    b_addr;
  logic [127:0]  b_data = '0;
  logic [3:0]    stripe_idx;
  logic [13:0]   best_score;
  logic [10:0]   best_end;
  logic          busy, done, err;
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    int st_pos;
    int end_pos;
    int score;
    int dly;
    int spos;
    int best;
    int bend;
  } vec_t;

  vec_t tbl [32];

  sw_stripe_feeder_if pe_if ();

  sw_stripe_feeder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_go         (go),
    .o_a_addr     (a_addr),
    .i_a_data     (a_data),
    .o_b_addr     (b_addr),
    .i_b_data     (b_data),
    .pe           (pe_if),
    .o_stripe_idx (stripe_idx),
    .o_best_score (best_score),
    .o_best_end   (best_end),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  function automatic base_t a_rom(input logic [9:0] a);
    return a[1:0] ^ a[5:4] ^ a[9:8];
  endfunction

  always @(posedge clk) begin
    a_data <= a_rom(a_addr);
    b_data <= {32{b_addr}};
  end

  function automatic vec_t mk(int st, int ep, int sc, int dl, int sp, int bs, int be);
    vec_t v;
    v.st_pos = st; v.end_pos = ep; v.score = sc; v.dly = dl;
    v.spos = sp; v.best = bs; v.bend = be;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Entered at the LOADB negedge; returns at the negedge after UPD.
  task automatic run_stripe(input int idx);
    vec_t v;
    int k, n, cnt, bad;
    v = tbl[idx];
    k = idx % 16;
    n = SEQ_LEN - v.spos;
    cnt = 0;
    bad = 0;
    chk("loadb_b_addr", b_addr, k);
    chk("loadb_stripe_idx", stripe_idx, k);
    chk("loadb_start_low", pe_if.o_pe_start, 0);
    chk("loadb_busy", busy, 1);
    @(negedge clk);
    chk("gap_start_low", pe_if.o_pe_start, 0);
    for (int s = 0; s <= n + v.dly; s++) begin
      @(negedge clk);
      if (s == 0) begin
        chk("pe_B_row", pe_if.o_pe_B, {32{4'(k)}});
        if (n > 0) chk("first_a_addr", a_addr, v.spos);
      end
      if (pe_if.o_pe_start) begin
        cnt++;
        if (pe_if.o_pe_A !== a_rom(10'(v.spos + cnt - 1))) bad++;
      end
      if (s == n + v.dly) begin
        pe_if.i_pe_stripe_end     = 1'b1;
        pe_if.i_pe_start_position = 10'(v.st_pos);
        pe_if.i_pe_end_position   = 10'(v.end_pos);
        pe_if.i_pe_max_score      = 14'(v.score);
      end
    end
    chk("pe_start_count", cnt, n);
    chk("pe_A_data_errs", bad, 0);
    @(negedge clk);
    pe_if.i_pe_stripe_end = 1'b0;
    chk("upd_start_low", pe_if.o_pe_start, 0);
    @(negedge clk);
    chk("best_score", best_score, v.best);
    chk("best_end", best_end, v.bend);
  endtask

  // Entered at the first TRACE negedge.
  task automatic trace_done();
    chk("trace_start_low", pe_if.o_pe_start, 0);
    chk("trace_pe_B_zero", pe_if.o_pe_B, 0);
    chk("trace_busy", busy, 1);
    pe_if.i_pe_stripe_end = 1'b1;
    @(negedge clk);
    chk("trace_no_early_done", done, 0);
    pe_if.i_pe_stripe_end = 1'b0;
    @(negedge clk);
    pe_if.i_pe_stripe_end = 1'b1;
    @(negedge clk);
    pe_if.i_pe_stripe_end = 1'b0;
    chk("trace_done", done, 1);
    chk("done_not_busy", busy, 0);
  endtask

  initial begin
    pe_if.i_pe_stripe_end     = 1'b0;
    pe_if.i_pe_start_position = '0;
    pe_if.i_pe_end_position   = '0;
    pe_if.i_pe_max_score      = '0;

    // Run A: start_position 0, scores exercise strict-greater and ties.
    tbl[0]  = mk(0,   10,     5, 0, 0,     5,   10);
    tbl[1]  = mk(0,   20,     9, 1, 0,     9,   20);
    tbl[2]  = mk(0,   30,     9, 2, 0,     9,   20);
    tbl[3]  = mk(0,   40,     7, 0, 0,     9,   20);
    tbl[4]  = mk(0,   50,     3, 1, 0,     9,   20);
    tbl[5]  = mk(0,   60,    12, 0, 0,    12,   60);
    tbl[6]  = mk(0,   70,    12, 1, 0,    12,   60);
    tbl[7]  = mk(0,   80,     2, 0, 0,    12,   60);
    tbl[8]  = mk(0,   90,     0, 0, 0,    12,   60);
    tbl[9]  = mk(0,  100,     1, 1, 0,    12,   60);
    tbl[10] = mk(0,  110,    11, 0, 0,    12,   60);
    tbl[11] = mk(0,  120,    13, 2, 0,    13,  120);
    tbl[12] = mk(0,  130,     4, 0, 0,    13,  120);
    tbl[13] = mk(0, 1023, 16383, 0, 0, 16383, 1023);
    tbl[14] = mk(0,    5, 16383, 1, 0, 16383, 1023);
    tbl[15] = mk(0,    7,     6, 0, 0, 16383, 1023);
    // Run B: start_position 100, spos saturates at 1024 from stripe 11.
    tbl[16] = mk(100,    7,  1, 0,    0,  1,    7);
    tbl[17] = mk(100,    7,  2, 1,  100,  2,  107);
    tbl[18] = mk(100,    7,  3, 0,  200,  3,  207);
    tbl[19] = mk(100,    7,  4, 2,  300,  4,  307);
    tbl[20] = mk(100,    7,  5, 0,  400,  5,  407);
    tbl[21] = mk(100,    7,  6, 1,  500,  6,  507);
    tbl[22] = mk(100,    7,  7, 0,  600,  7,  607);
    tbl[23] = mk(100,    7,  8, 0,  700,  8,  707);
    tbl[24] = mk(100,    7,  9, 1,  800,  9,  807);
    tbl[25] = mk(100,    7, 10, 0,  900, 10,  907);
    tbl[26] = mk(100,    7, 11, 3, 1000, 11, 1007);
    tbl[27] = mk(100,    7, 12, 0, 1024, 12, 1031);
    tbl[28] = mk(100,    7, 13, 3, 1024, 13, 1031);
    tbl[29] = mk(100,    7, 14, 1, 1024, 14, 1031);
    tbl[30] = mk(100,    7, 15, 0, 1024, 15, 1031);
    tbl[31] = mk(100, 1023, 16, 2, 1024, 16, 2047);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pe_start", pe_if.o_pe_start, 0);
    chk("rst_pe_A", pe_if.o_pe_A, 0);
    chk("rst_pe_B", pe_if.o_pe_B, 0);
    chk("rst_stripe_idx", stripe_idx, 0);
    chk("rst_best_score", best_score, 0);
    chk("rst_best_end", best_end, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_b_addr", b_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    go = 1'b1; @(negedge clk); go = 1'b0;
    for (int i = 0; i < 16; i++) run_stripe(i);
    trace_done();

    pe_if.i_pe_stripe_end = 1'b1;
    @(negedge clk);
    pe_if.i_pe_stripe_end = 1'b0;
    chk("done_ignores_stripe_end", done, 1);
    chk("done_holds_best", best_score, 16383);

    go = 1'b1; @(negedge clk); go = 1'b0;
    for (int i = 16; i < 32; i++) run_stripe(i);
    trace_done();

    // Run C: reset while stripe 3 is streaming valid A.
    go = 1'b1; @(negedge clk); go = 1'b0;
    for (int i = 0; i < 3; i++) run_stripe(i);
    @(negedge clk);
    for (int s = 0; s <= 500; s++) @(negedge clk);
    chk("mid_stream_start_high", pe_if.o_pe_start, 1);
    chk("mid_stream_idx", stripe_idx, 3);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_start", pe_if.o_pe_start, 0);
    chk("async_rst_idx", stripe_idx, 0);
    chk("async_rst_best", best_score, 0);
    chk("async_rst_best_end", best_end, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pe_B", pe_if.o_pe_B, 0);

    // Run D: stripe_end withheld.
    go = 1'b1; @(negedge clk); go = 1'b0;
    chk("d_loadb_err", err, 0);
    @(negedge clk);
    for (int s = 0; s < 2100; s++) begin
      @(negedge clk);
`ifdef FEEDER_TIMEOUT_EN
      if (s == 1999) chk("tmo_not_yet", done, 0);
      if (s == 2000) begin
        chk("tmo_err", err, 1);
        chk("tmo_done", done, 1);
      end
      if (s == 2099) chk("tmo_err_sticky", err, 1);
`else
      if (s == 2099) begin
        chk("no_tmo_busy", busy, 1);
        chk("no_tmo_done", done, 0);
        chk("no_tmo_err", err, 0);
      end
`endif
    end
`ifdef FEEDER_TIMEOUT_EN
    go = 1'b1; @(negedge clk); go = 1'b0;
    chk("tmo_err_cleared_by_go", err, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
